// File: rtl/sha256_arbiter_if.sv
// Bundle of requester, core and response signals shared by the sha256 arbiter.
// The arbiter sits on the slave side; requesters, the core and the response consumer sit on the master side.
interface sha256_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req;
    logic [512*N_REQ-1:0]   req_block;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic                   core_start;
    logic [511:0]           core_block;
    logic [255:0]           core_digest;
    logic                   core_finish;
    logic                   resp_valid;
    logic [IDX_W-1:0]       resp_id;
    logic [255:0]           resp_digest;
    logic                   resp_error;

    modport master (
        output req, req_block, core_digest, core_finish,
        input  grant, busy, core_start, core_block,
        input  resp_valid, resp_id, resp_digest, resp_error
    );

    modport slave (
        input  req, req_block, core_digest, core_finish,
        output grant, busy, core_start, core_block,
        output resp_valid, resp_id, resp_digest, resp_error
    );
endinterface

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter sharing one sha256 compression core among N_REQ requesters.
// Includes a watchdog that turns a core which never finishes into an error response.
module sha256_arbiter #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = $clog2(N_REQ),
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    sha256_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESPOND} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
    logic [IDX_W-1:0] cur_id, cur_id_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [N_REQ-1:0] grant_q, grant_next;
    logic             busy_q, busy_next;
    logic             start_q, start_next;
    logic [511:0]     block_q, block_next;
    logic             valid_q, valid_next;
    logic [IDX_W-1:0] resp_id_q, resp_id_next;
    logic [255:0]     digest_q, digest_next;
    logic             error_q, error_next;

    logic [IDX_W-1:0] winner;
    logic             found;
    logic [IDX_W:0]   cand;

    // Scan upward from rr_ptr with an explicit wrap so non-power-of-two N_REQ works.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!found && bus.req[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_next   = state;
        rr_ptr_next  = rr_ptr;
        cur_id_next  = cur_id;
        cnt_next     = cnt;
        grant_next   = '0;
        start_next   = 1'b0;
        block_next   = block_q;
        valid_next   = 1'b0;
        resp_id_next = resp_id_q;
        digest_next  = digest_q;
        error_next   = error_q;

        case (state)
            IDLE: begin
                if (found) begin
                    state_next         = LAUNCH;
                    cur_id_next        = winner;
                    block_next         = bus.req_block[512*winner +: 512];
                    grant_next[winner] = 1'b1;
                    start_next         = 1'b1;
                    rr_ptr_next        = (winner == IDX_W'(N_REQ-1)) ? '0 : winner + 1'b1;
                end
            end
            LAUNCH: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                cnt_next = cnt + 1'b1;
                // A finish arriving on the timeout cycle still counts as success.
                if (bus.core_finish) begin
                    digest_next  = bus.core_digest;
                    error_next   = 1'b0;
                    valid_next   = 1'b1;
                    resp_id_next = cur_id;
                    state_next   = RESPOND;
                end else if (cnt == CNT_W'(TIMEOUT-1)) begin
                    digest_next  = '0;
                    error_next   = 1'b1;
                    valid_next   = 1'b1;
                    resp_id_next = cur_id;
                    state_next   = RESPOND;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            cnt       <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            block_q   <= '0;
            valid_q   <= 1'b0;
            resp_id_q <= '0;
            digest_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_ptr_next;
            cur_id    <= cur_id_next;
            cnt       <= cnt_next;
            grant_q   <= grant_next;
            busy_q    <= busy_next;
            start_q   <= start_next;
            block_q   <= block_next;
            valid_q   <= valid_next;
            resp_id_q <= resp_id_next;
            digest_q  <= digest_next;
            error_q   <= error_next;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.core_start  = start_q;
    assign bus.core_block  = block_q;
    assign bus.resp_valid  = valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_digest = digest_q;
    assign bus.resp_error  = error_q;
endmodule

// File: tb/tb_sha256_arbiter.sv
// Directed bench for sha256_arbiter: one instance with the default watchdog, one with a short watchdog.
// Expected responses are queued when a job is finished or left to time out, and checked when resp_valid appears.
module tb_sha256_arbiter;
    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    localparam int TO_T  = 16;

    typedef struct {
        logic [IDX_W-1:0] id;
        logic [255:0]     digest;
        logic             error;
    } resp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic [N_REQ-1:0] req_a, req_t;
    logic             fin_a, fin_t;
    logic [255:0]     digest_in;
    logic [511:0]     blocks [N_REQ];

    int    compared   = 0;
    int    mismatched = 0;
    resp_t exp_a[$];
    resp_t exp_t[$];
    resp_t pop_a, pop_t;

    sha256_arbiter_if #(.N_REQ(N_REQ)) bus_a ();
    sha256_arbiter_if #(.N_REQ(N_REQ)) bus_t ();

    assign bus_a.req         = req_a;
    assign bus_a.req_block   = {blocks[3], blocks[2], blocks[1], blocks[0]};
    assign bus_a.core_digest = digest_in;
    assign bus_a.core_finish = fin_a;
    assign bus_t.req         = req_t;
    assign bus_t.req_block   = {blocks[3], blocks[2], blocks[1], blocks[0]};
    assign bus_t.core_digest = digest_in;
    assign bus_t.core_finish = fin_t;

    sha256_arbiter #(.N_REQ(N_REQ)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    sha256_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TO_T)) dut_t (
        .clock (clock),
        .reset (reset),
        .bus   (bus_t)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit to_t, input logic [N_REQ-1:0] r);
        if (to_t) req_t = r;
        else      req_a = r;
    endtask

    function automatic logic [255:0] randDigest();
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom();
        return d;
    endfunction

    // Every response must match the single job outstanding on that instance.
    always @(negedge clock) begin
        if (bus_a.resp_valid === 1'b1) begin
            checkOutput("resp_a_outstanding", 512'(exp_a.size()), 512'(1));
            if (exp_a.size() > 0) begin
                pop_a = exp_a.pop_front();
                checkOutput("resp_a_id", 512'(bus_a.resp_id), 512'(pop_a.id));
                checkOutput("resp_a_digest", 512'(bus_a.resp_digest), 512'(pop_a.digest));
                checkOutput("resp_a_error", 512'(bus_a.resp_error), 512'(pop_a.error));
            end
        end
        if (bus_t.resp_valid === 1'b1) begin
            checkOutput("resp_t_outstanding", 512'(exp_t.size()), 512'(1));
            if (exp_t.size() > 0) begin
                pop_t = exp_t.pop_front();
                checkOutput("resp_t_id", 512'(bus_t.resp_id), 512'(pop_t.id));
                checkOutput("resp_t_digest", 512'(bus_t.resp_digest), 512'(pop_t.digest));
                checkOutput("resp_t_error", 512'(bus_t.resp_error), 512'(pop_t.error));
            end
        end
    end

    task automatic finishJob(input string tag, input int id);
        logic [255:0] d;
        d = randDigest();
        exp_a.push_back('{IDX_W'(id), d, 1'b0});
        digest_in = d;
        fin_a     = 1'b1;
        tick();
        fin_a = 1'b0;
        checkOutput({tag, "_resp_seen"}, 512'(exp_a.size()), 512'(0));
        tick();
        checkOutput({tag, "_idle"}, 512'(bus_a.busy), 512'(0));
    endtask

    task automatic doJob(input string tag, input logic [N_REQ-1:0] exp_grant, input int exp_id,
                         input int latency, input bit drop);
        for (int i = 0; i < 64 && bus_a.grant === '0; i++) tick();
        checkOutput({tag, "_grant"}, 512'(bus_a.grant), 512'(exp_grant));
        checkOutput({tag, "_start"}, 512'(bus_a.core_start), 512'(1));
        checkOutput({tag, "_busy"}, 512'(bus_a.busy), 512'(1));
        checkOutput({tag, "_block"}, bus_a.core_block, blocks[exp_id]);
        if (drop) applyStimulus(1'b0, '0);
        tick();
        checkOutput({tag, "_grant_pulse"}, 512'(bus_a.grant), 512'(0));
        checkOutput({tag, "_start_pulse"}, 512'(bus_a.core_start), 512'(0));
        repeat (latency - 1) tick();
        finishJob(tag, exp_id);
    endtask

    initial begin
        logic [255:0] d;
        reset     = 1'b1;
        req_a     = '0;
        req_t     = '0;
        fin_a     = 1'b0;
        fin_t     = 1'b0;
        digest_in = '0;
        for (int i = 0; i < N_REQ; i++)
            for (int w = 0; w < 16; w++) blocks[i][w*32 +: 32] = $urandom();

        tick();
        tick();
        checkOutput("rst_grant", 512'(bus_a.grant), 512'(0));
        checkOutput("rst_busy", 512'(bus_a.busy), 512'(0));
        checkOutput("rst_start", 512'(bus_a.core_start), 512'(0));
        checkOutput("rst_block", bus_a.core_block, 512'(0));
        checkOutput("rst_valid", 512'(bus_a.resp_valid), 512'(0));
        checkOutput("rst_id", 512'(bus_a.resp_id), 512'(0));
        checkOutput("rst_digest", 512'(bus_a.resp_digest), 512'(0));
        checkOutput("rst_error", 512'(bus_a.resp_error), 512'(0));
        reset = 1'b0;
        tick();

        $display("[TB] round-robin with all requesters pending");
        applyStimulus(1'b0, 4'b1111);
        for (int j = 0; j < 8; j++)
            doJob($sformatf("rr%0d", j), N_REQ'(1) << (j % 4), j % 4, 3 + j, 1'b0);
        applyStimulus(1'b0, '0);

        $display("[TB] single request with 64-cycle core");
        applyStimulus(1'b0, 4'b0010);
        doJob("single", 4'b0010, 1, 64, 1'b1);

        $display("[TB] pointer wrap");
        applyStimulus(1'b0, 4'b1000);
        doJob("wrap_a", 4'b1000, 3, 5, 1'b1);
        applyStimulus(1'b0, 4'b1001);
        doJob("wrap_b", 4'b0001, 0, 5, 1'b0);
        doJob("wrap_c", 4'b1000, 3, 5, 1'b1);

        $display("[TB] finish pulses outside WAIT");
        fin_a = 1'b1;
        tick();
        fin_a = 1'b0;
        checkOutput("idle_fin_valid", 512'(bus_a.resp_valid), 512'(0));
        checkOutput("idle_fin_busy", 512'(bus_a.busy), 512'(0));
        tick();
        checkOutput("idle_fin_valid2", 512'(bus_a.resp_valid), 512'(0));
        applyStimulus(1'b0, 4'b0100);
        tick();
        checkOutput("launch_grant", 512'(bus_a.grant), 512'(4'b0100));
        applyStimulus(1'b0, '0);
        fin_a = 1'b1;
        tick();
        fin_a = 1'b0;
        tick();
        checkOutput("launch_fin_valid", 512'(bus_a.resp_valid), 512'(0));
        tick();
        checkOutput("launch_fin_valid2", 512'(bus_a.resp_valid), 512'(0));
        checkOutput("launch_fin_busy", 512'(bus_a.busy), 512'(1));
        finishJob("launch", 2);

        $display("[TB] reset during WAIT");
        applyStimulus(1'b0, 4'b0010);
        tick();
        checkOutput("abort_grant", 512'(bus_a.grant), 512'(4'b0010));
        applyStimulus(1'b0, '0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        checkOutput("abort_grant0", 512'(bus_a.grant), 512'(0));
        checkOutput("abort_busy", 512'(bus_a.busy), 512'(0));
        checkOutput("abort_start", 512'(bus_a.core_start), 512'(0));
        checkOutput("abort_block", bus_a.core_block, 512'(0));
        checkOutput("abort_valid", 512'(bus_a.resp_valid), 512'(0));
        checkOutput("abort_digest", 512'(bus_a.resp_digest), 512'(0));
        reset = 1'b0;
        tick();
        tick();
        checkOutput("abort_no_resp", 512'(bus_a.resp_valid), 512'(0));
        applyStimulus(1'b0, 4'b1010);
        doJob("post_reset", 4'b0010, 1, 4, 1'b1);

        $display("[TB] watchdog timeout");
        applyStimulus(1'b1, 4'b0001);
        tick();
        checkOutput("to_grant", 512'(bus_t.grant), 512'(4'b0001));
        checkOutput("to_start", 512'(bus_t.core_start), 512'(1));
        applyStimulus(1'b1, '0);
        exp_t.push_back('{IDX_W'(0), 256'(0), 1'b1});
        repeat (TO_T) tick();
        checkOutput("to_early", 512'(bus_t.resp_valid), 512'(0));
        tick();
        checkOutput("to_valid", 512'(bus_t.resp_valid), 512'(1));
        checkOutput("to_resp_seen", 512'(exp_t.size()), 512'(0));
        tick();
        checkOutput("to_idle", 512'(bus_t.busy), 512'(0));

        $display("[TB] finish on the timeout cycle");
        applyStimulus(1'b1, 4'b0010);
        tick();
        checkOutput("tie_grant", 512'(bus_t.grant), 512'(4'b0010));
        applyStimulus(1'b1, '0);
        repeat (TO_T) tick();
        d = randDigest();
        exp_t.push_back('{IDX_W'(1), d, 1'b0});
        digest_in = d;
        fin_t     = 1'b1;
        tick();
        fin_t = 1'b0;
        checkOutput("tie_valid", 512'(bus_t.resp_valid), 512'(1));
        checkOutput("tie_resp_seen", 512'(exp_t.size()), 512'(0));
        tick();
        checkOutput("tie_idle", 512'(bus_t.busy), 512'(0));

        tick();
        checkOutput("final_queue_a", 512'(exp_a.size()), 512'(0));
        checkOutput("final_queue_t", 512'(exp_t.size()), 512'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
